// File: rtl/video_pkg.sv
// Shared definitions for the video pattern generator: pattern modes,
// default 640x480 timing constants and the colour-bar lookup.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_GRADIENT = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_SOLID    = 2'd3
  } pattern_mode_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Eight-bar table, left to right. Each entry is {R,G,B} on/off;
  // "on" means the channel is driven to full scale.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;  // white
      3'd1:    rgb = 3'b110;  // yellow
      3'd2:    rgb = 3'b011;  // cyan
      3'd3:    rgb = 3'b010;  // green
      3'd4:    rgb = 3'b101;  // magenta
      3'd5:    rgb = 3'b100;  // red
      3'd6:    rgb = 3'b001;  // blue
      default: rgb = 3'b000;  // black
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Video output bus of the pattern generator: colour channels, blanking,
// syncs and the frame-start marker. The generator drives it through the
// master modport; a display sink or bench observes it through slave.
interface video_pattern_gen_if #(
  parameter int COLOUR_W = 8
);

  logic [COLOUR_W-1:0] vga_red_o;
  logic [COLOUR_W-1:0] vga_green_o;
  logic [COLOUR_W-1:0] vga_blue_o;
  logic                vga_blank_o;
  logic                vga_hsync_o;
  logic                vga_vsync_o;
  logic                frame_start_o;

  modport master (
    output vga_red_o, vga_green_o, vga_blue_o,
    output vga_blank_o, vga_hsync_o, vga_vsync_o,
    output frame_start_o
  );

  modport slave (
    input vga_red_o, vga_green_o, vga_blue_o,
    input vga_blank_o, vga_hsync_o, vga_vsync_o,
    input frame_start_o
  );

endinterface

// File: rtl/video_timing.sv
// Raster timing: horizontal/vertical pixel counters plus the combinational
// decode of active area, sync windows and the frame boundary. Counters are
// held at (0,0) while disabled so a restart always begins a clean frame.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hsync_on,
  output logic          vsync_on,
  output logic          frame_begin
);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Advance the raster position; end of line bumps the line counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Decode visible area, sync windows and the first pixel of a frame.
  always_comb begin
    active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync_on    = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
    vsync_on    = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);
    frame_begin = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: colour bars, gradient, checkerboard or a solid
// colour, with VGA-style blanking and syncs. All outputs are registered one
// cycle behind the raster counters. Pattern selection is captured at the
// frame boundary so a frame is never split between two patterns.
// Optional build macro VIDEO_PATTERN_GEN_MOTION_EN adds an 8-bit frame
// counter that scrolls the bars/gradient/checkerboard horizontally.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COLOUR_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [1:0]            mode_i,
  input  logic [3*COLOUR_W-1:0] solid_rgb_i,
  video_pattern_gen_if.master   vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic                  active;
  logic                  hsync_on;
  logic                  vsync_on;
  logic                  frame_begin;

  pattern_mode_e         mode_q;
  pattern_mode_e         mode_cur;
  logic [3*COLOUR_W-1:0] solid_q;
  logic [3*COLOUR_W-1:0] solid_cur;

  logic [HW-1:0]         x_pix;
  logic [2:0]            bar_idx;
  logic [2:0]            bar_on;
  logic [COLOUR_W-1:0]   grad;
  logic                  cell_dark;
  logic [3*COLOUR_W-1:0] pix_rgb;

  logic [COLOUR_W-1:0]   red_q;
  logic [COLOUR_W-1:0]   green_q;
  logic [COLOUR_W-1:0]   blue_q;
  logic                  blank_q;
  logic                  hsync_q;
  logic                  vsync_q;
  logic                  frame_start_q;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hsync_on    (hsync_on),
    .vsync_on    (vsync_on),
    .frame_begin (frame_begin)
  );

  // Capture pattern selection and solid colour once per frame.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mode_q  <= MODE_BARS;
      solid_q <= '0;
    end else if (enable_i && frame_begin) begin
      mode_q  <= pattern_mode_e'(mode_i);
      solid_q <= solid_rgb_i;
    end
  end

  // The boundary pixel itself already belongs to the new frame, so it
  // uses the live inputs rather than the previous frame's latched copy.
  always_comb begin
    mode_cur  = frame_begin ? pattern_mode_e'(mode_i) : mode_q;
    solid_cur = frame_begin ? solid_rgb_i : solid_q;
  end

`ifdef VIDEO_PATTERN_GEN_MOTION_EN
  logic [7:0] frame_cnt;

  // Count completed frames; the offset changes exactly at the wrap to (0,0).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      frame_cnt <= '0;
    end else if (!enable_i) begin
      frame_cnt <= '0;
    end else if ((h_cnt == HW'(H_TOTAL - 1)) && (v_cnt == VW'(V_TOTAL - 1))) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Scroll the pattern coordinate by the frame count, wrapping at x width.
  always_comb begin
    x_pix = h_cnt + HW'(frame_cnt);
  end
`else
  // Static pattern: the pattern coordinate is the raster column.
  always_comb begin
    x_pix = h_cnt;
  end
`endif

  // Pattern generation for the current raster position.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_pix >= HW'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
    bar_on    = bar_rgb(bar_idx);
    grad      = COLOUR_W'(x_pix);
    cell_dark = x_pix[5] ^ v_cnt[5];
    pix_rgb   = '0;
    case (mode_cur)
      MODE_BARS:     pix_rgb = {{COLOUR_W{bar_on[2]}},
                                {COLOUR_W{bar_on[1]}},
                                {COLOUR_W{bar_on[0]}}};
      MODE_GRADIENT: pix_rgb = {grad, grad, grad};
      MODE_CHECKER:  pix_rgb = {3*COLOUR_W{~cell_dark}};
      MODE_SOLID:    pix_rgb = solid_cur;
      default:       pix_rgb = '0;
    endcase
  end

  // Output stage: one register for every output keeps them aligned.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      blank_q       <= 1'b1;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      frame_start_q <= 1'b0;
    end else if (!enable_i) begin
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      blank_q       <= 1'b1;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      red_q         <= active ? pix_rgb[3*COLOUR_W-1 -: COLOUR_W] : '0;
      green_q       <= active ? pix_rgb[2*COLOUR_W-1 -: COLOUR_W] : '0;
      blue_q        <= active ? pix_rgb[COLOUR_W-1:0]             : '0;
      blank_q       <= ~active;
      hsync_q       <= hsync_on ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= vsync_on ? VSYNC_POL : ~VSYNC_POL;
      frame_start_q <= frame_begin;
    end
  end

  assign vga.vga_red_o     = red_q;
  assign vga.vga_green_o   = green_q;
  assign vga.vga_blue_o    = blue_q;
  assign vga.vga_blank_o   = blank_q;
  assign vga.vga_hsync_o   = hsync_q;
  assign vga.vga_vsync_o   = vsync_q;
  assign vga.frame_start_o = frame_start_q;

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC and H_BP, defaults 16, 96 and 48, meaning horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 480, 10, 2 and 33, meaning the vertical equivalents in lines.
REQ-004 SHALL have parameters HSYNC_POL and VSYNC_POL, default 0, meaning the asserted sync level (0 = active-low).
REQ-005 SHALL have parameter COLOUR_W, default 8, meaning bits per colour channel.
REQ-006 clk_i  input  1  pixel clock; one clock, all logic on its rising edge.
REQ-007 rst_i  input  1  reset, asynchronous, active-low.
REQ-008 enable_i  input  1  run timing when high.
REQ-009 mode_i  input  2  pattern select: 0 bars, 1 gradient, 2 checkerboard, 3 solid.
REQ-010 solid_rgb_i  input  3*COLOUR_W  solid colour {R,G,B}.
REQ-011 vga_red_o, vga_green_o, vga_blue_o  output  COLOUR_W each  pixel colour.
REQ-012 vga_blank_o  output  1  high outside the active area.
REQ-013 vga_hsync_o, vga_vsync_o  output  1 each  syncs at the configured polarity.
REQ-014 frame_start_o  output  1  one-cycle pulse coincident with output pixel (0,0).

Function
REQ-015 SHALL keep h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters), wrapping to 0 and advancing v_cnt; v_cnt 0..V_TOTAL-1 wraps to 0.
REQ-016 SHALL define the active area as h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; x=h_cnt, y=v_cnt.
REQ-017 SHALL assert hsync for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and vsync for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] over whole lines.
REQ-018 SHALL register all outputs, with fixed one-cycle latency from counter state; colour, blank, syncs and frame_start_o aligned.
REQ-019 SHALL drive colour to 0 whenever blank is high.
REQ-020 SHALL sample mode_i and solid_rgb_i only when h_cnt=0 and v_cnt=0 (frame boundary); mid-frame changes take effect next frame.
REQ-021 Mode 0: SHALL use bar index x/(H_ACTIVE/8), clamped to 7, ordered white, yellow, cyan, green, magenta, red, blue, black; full scale = all ones.
REQ-022 Mode 1: SHALL drive R=G=B=x[COLOUR_W-1:0], wrapping every 2^COLOUR_W pixels.
REQ-023 Mode 2: SHALL drive white when x[5]^y[5]=0, else black (32x32 cells).
REQ-024 Mode 3: SHALL drive the latched solid colour.
REQ-025 SHALL, while enable_i is low, force counters to 0, blank high, syncs inactive and frame_start_o low; on rising enable_i, counting starts at (0,0) on the next cycle and mode is re-sampled.

Reset
REQ-026 SHALL on rst_i low clear counters and latched mode (0) and solid colour (0), and drive colour 0, blank 1, syncs inactive level, frame_start_o 0.
REQ-027 SHALL, on reset deassertion mid-frame, restart from (0,0) with no partial sync pulse.

Configuration
REQ-028 With VIDEO_PATTERN_GEN_MOTION_EN defined, SHALL keep an 8-bit frame counter (incremented at each frame boundary, wrapping 255->0, cleared by reset or disable) and use x+frame_cnt (modulo the x width) in place of x for modes 0-2.
REQ-029 Without VIDEO_PATTERN_GEN_MOTION_EN, SHALL have no frame counter; patterns are static.

Structure
REQ-030 SHALL place the mode enumeration, 8-bar colour table and default 640x480 timing constants in shared package video_pkg.
REQ-031 SHALL implement counters and sync decode in sub-module video_timing; pattern logic and output registers remain in video_pattern_gen.

Verification
REQ-032 Defaults, enable_i=1: hsync low for 96 clocks every 800; vsync low for 2 lines every 525; blank low for exactly 640x480 pixels per frame.
REQ-033 H_ACTIVE=16, mode 0: bars 2 pixels wide; pixels 0-1 = FF/FF/FF, 14-15 = 00/00/00.
REQ-034 mode_i 0->3 at line 100 with solid_rgb_i=123456: frame unchanged; next frame every active pixel = 12/34/56.
REQ-035 rst_i low at h_cnt=700, line 490: all outputs at reset values immediately; after release, frame_start_o after 1 cycle and first hsync at clock 657.
REQ-036 enable_i low for 50 cycles mid-line: blank=1, syncs inactive; after re-enable, frame_start_o one cycle later.
REQ-037 MOTION_EN defined, mode 1: pixel x=0 of frame n = n mod 256; frame 256 matches frame 0.
